// File: rtl/darksram_pkg.sv
// darksram_pkg: FSM state encoding and default parameters for the dark SRAM controller.
package darksram_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DEF_DEPTH = 512;
  localparam int DEF_LATENCY = 0;
  localparam logic [31:0] DEF_BASE = 32'h0000_0000;
endpackage

// File: rtl/darksram_bank.sv
// darksram_bank: DEPTH x 32 word array with byte write enables and a registered read port.
module darksram_bank #(
  parameter int DEPTH = 512,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/darksram_ctrl.sv
// darksram_ctrl: single-outstanding bus slave in front of darksram_bank with range check and read wait states.
module darksram_ctrl
  import darksram_pkg::*;
#(
  parameter int          DEPTH   = DEF_DEPTH,
  parameter int          LATENCY = DEF_LATENCY,
  parameter logic [31:0] BASE    = DEF_BASE
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        BUS_EN,
  input  logic        BUS_RW,
  input  logic [3:0]  BUS_BE,
  input  logic [31:0] BUS_ADDR,
  input  logic [31:0] BUS_WDATA,
  output logic [31:0] BUS_RDATA,
  output logic        BUS_VALID,
  output logic        BUS_ERR
);
  localparam int AW = $clog2(DEPTH);
  state_t state;
  logic [2:0] cnt;
  logic hit_q, rw_q, acc, hit;
  logic [31:0] off, rd;
  logic [3:0] we;
  // An address below BASE wraps to a huge offset, so one unsigned compare covers both bounds.
  assign off = BUS_ADDR - BASE;
  assign hit = off < 32'(DEPTH * 4);
  assign acc = state == IDLE && BUS_EN;
  assign we = (acc && BUS_RW && hit) ? (BUS_BE == 4'h0 ? 4'hf : BUS_BE) : 4'h0;
  darksram_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
    .clk(XCLK), .we(we), .re(acc && !BUS_RW), .addr(off[AW+1:2]), .wdata(BUS_WDATA), .rdata(rd)
  );
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      state <= IDLE;
      cnt <= 3'd0;
      hit_q <= 1'b0;
      rw_q <= 1'b0;
    end else if (acc) begin
      hit_q <= hit;
      rw_q <= BUS_RW;
      state <= (BUS_RW || LATENCY == 0) ? RESP : WAIT;
      cnt <= BUS_RW ? 3'd0 : 3'(LATENCY);
    end else if (state == WAIT) begin
      cnt <= cnt - 3'd1;
      if (cnt == 3'd1) state <= RESP;
    end else if (state == RESP) begin
      state <= IDLE;
    end
  end
  assign BUS_VALID = state == RESP;
  assign BUS_ERR = BUS_VALID && !hit_q;
  assign BUS_RDATA = (BUS_VALID && hit_q && !rw_q) ? rd : 32'h0;
endmodule

// File: tb/tb_darksram_ctrl.sv
// tb_darksram_ctrl: three controllers (LATENCY 0/3/5) checked every cycle against a transaction-level model.
module tb_darksram_ctrl;
  localparam int DEPTH = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic clk = 0, xres = 0;
  logic en [3], rw [3], valid [3], err [3];
  logic [3:0] be [3];
  logic [31:0] addr [3], wdata [3], rdata [3];
  int lat [3] = '{0, 3, 5};
  int cyc = 0, nvec = 0, nerr = 0, pulses = 0;
  bit pend [3], erd [3];
  int vcyc [3], free [3];
  logic [31:0] edata [3];
  logic eerr [3];
  logic [31:0] mmem [3][DEPTH];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    darksram_ctrl #(.DEPTH(DEPTH), .LATENCY(g == 0 ? 0 : g == 1 ? 3 : 5), .BASE(BASE)) dut (
      .XCLK(clk), .XRES(xres), .BUS_EN(en[g]), .BUS_RW(rw[g]), .BUS_BE(be[g]), .BUS_ADDR(addr[g]),
      .BUS_WDATA(wdata[g]), .BUS_RDATA(rdata[g]), .BUS_VALID(valid[g]), .BUS_ERR(err[g])
    );
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid[0]) pulses <= pulses + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, got, exp);
    end
  endtask
  // Outputs must pulse exactly on the model's predicted cycle and be zero at all other times.
  always @(negedge clk)
    for (int k = 0; k < 3; k++) begin
      bit ev;
      ev = pend[k] && cyc == vcyc[k];
      chk($sformatf("valid%0d", k), 32'(valid[k]), 32'(ev));
      chk($sformatf("err%0d", k), 32'(err[k]), ev ? 32'(eerr[k]) : 32'h0);
      if (!ev || erd[k]) chk($sformatf("rdata%0d", k), rdata[k], ev ? edata[k] : 32'h0);
    end
  task automatic access(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input bit hold,
                        output logic [31:0] gd, output logic ge, output int glat);
    int acc, vc, fv, ix;
    longint off;
    bit h;
    en[k] = 1; rw[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
    acc = (cyc + 1 > free[k]) ? cyc + 1 : free[k];
    vc = acc + (w ? 0 : lat[k]);
    off = longint'(a) - longint'(BASE);
    h = off >= 0 && off < DEPTH * 4;
    edata[k] = 32'h0;
    if (h) begin
      ix = int'(off / 4);
      if (w) begin
        for (int i = 0; i < 4; i++) if (b == 4'h0 || b[i]) mmem[k][ix][8*i +: 8] = d[8*i +: 8];
      end else edata[k] = mmem[k][ix];
    end
    eerr[k] = !h; erd[k] = !w; vcyc[k] = vc; pend[k] = 1; free[k] = vc + 2;
    fv = -1; gd = 32'h0; ge = 1'b0;
    while (cyc < vc) begin
      @(negedge clk);
      if (valid[k] && fv < 0) begin fv = cyc; gd = rdata[k]; ge = err[k]; end
    end
    #1;
    if (!hold) en[k] = 0;
    glat = fv < 0 ? -1 : fv - acc + 1;
  endtask
  initial begin
    logic [31:0] gd;
    logic ge;
    int gl, p0;
    for (int k = 0; k < 3; k++) begin
      en[k] = 0; rw[k] = 0; be[k] = 0; addr[k] = 0; wdata[k] = 0; free[k] = 0;
    end
    repeat (3) @(negedge clk);
    #1 xres = 1;
    access(0, 1, 4'h0, BASE + 8, 32'hDEADBEEF, 0, gd, ge, gl);
    chk("wr_err", 32'(ge), 32'h0);
    chk("wr_lat", gl, 1);
    access(0, 0, 4'h0, BASE + 8, 0, 0, gd, ge, gl);
    chk("rd_data", gd, 32'hDEADBEEF);
    chk("rd_lat0", gl, 1);
    access(0, 1, 4'h0, BASE + 12, 32'h11223344, 0, gd, ge, gl);
    access(0, 1, 4'b0100, BASE + 12, 32'hAABBCCDD, 0, gd, ge, gl);
    access(0, 0, 4'h0, BASE + 12, 0, 0, gd, ge, gl);
    chk("byte_lane", gd, 32'h11BB3344);
    access(0, 1, 4'h0, BASE + DEPTH * 4 - 4, 32'h55AA55AA, 0, gd, ge, gl);
    access(0, 0, 4'h0, BASE + DEPTH * 4 - 4, 0, 0, gd, ge, gl);
    chk("last_word", gd, 32'h55AA55AA);
    access(0, 0, 4'h0, BASE + DEPTH * 4, 0, 0, gd, ge, gl);
    chk("miss_rd_err", 32'(ge), 32'h1);
    chk("miss_rd_data", gd, 32'h0);
    access(0, 1, 4'h0, BASE - 4, 32'hFFFFFFFF, 0, gd, ge, gl);
    chk("miss_wr_err", 32'(ge), 32'h1);
    access(0, 0, 4'h0, BASE + DEPTH * 4 - 4, 0, 0, gd, ge, gl);
    chk("miss_no_write", gd, 32'h55AA55AA);
    p0 = pulses;
    for (int i = 0; i < 4; i++)
      access(0, 1, 4'h0, BASE + 16 + 4 * i, 32'hC0DE0000 + i, i < 3, gd, ge, gl);
    @(negedge clk); #1;
    chk("b2b_pulses", pulses - p0, 4);
    for (int i = 0; i < 4; i++) access(0, 0, 4'h0, BASE + 16 + 4 * i, 0, 0, gd, ge, gl);
    access(1, 1, 4'h0, BASE + 4, 32'h0BADF00D, 0, gd, ge, gl);
    chk("wr_lat_l3", gl, 1);
    access(1, 0, 4'h0, BASE + 4, 0, 0, gd, ge, gl);
    chk("rd_lat_l3", gl, 4);
    chk("rd_data_l3", gd, 32'h0BADF00D);
    access(2, 1, 4'h0, BASE + 8, 32'h12345678, 0, gd, ge, gl);
    access(2, 0, 4'h0, BASE + 8, 0, 0, gd, ge, gl);
    chk("rd_lat_l5", gl, 6);
    // Read that reset abandons: the model expects no response at all.
    en[2] = 1; rw[2] = 0; addr[2] = BASE + 8;
    repeat (3) @(negedge clk);
    #1 xres = 0;
    repeat (2) @(negedge clk);
    #1 xres = 1;
    for (int k = 0; k < 3; k++) free[k] = 0;
    access(2, 0, 4'h0, BASE + 8, 0, 0, gd, ge, gl);
    chk("post_rst_data", gd, 32'h12345678);
    chk("post_rst_lat", gl, 6);
    access(0, 0, 4'h0, BASE + 8, 0, 0, gd, ge, gl);
    chk("post_rst_keep", gd, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
